cmd_packet_tx: RTL and testbench

Command-side packet transmitter, the sending end of the team's user-defined UART packet protocol. It buffers up to 15 16-bit words, then serializes a framed packet: sync byte, header {opcode, word count}, payload words MSB byte first, and an 8-bit checksum, all as 8N1 UART. It drives the FPGA rx line from a host-emulation/bench node or a second board, and retains the last packet so a retransmit request can be serviced.

---
 rtl/cmd_packet_tx.sv | 113 +++++++++++
 tb/tb_cmd_packet_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_packet_tx.sv
// cmd_packet_tx: buffers up to 15 words and sends them as a framed 8N1 UART packet (sync, header, payload, checksum)
module cmd_packet_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_word,
  input  logic [15:0] i_word,
  input  logic [3:0]  i_opcode,
  input  logic        i_send,
  input  logic        i_resend,
  output logic        o_tx_serial,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_word_cnt,
  output logic        o_full
);
  localparam int            BW       = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HDR, S_DHI, S_DLO, S_CSUM} state_t;
  state_t        r_state, w_next;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit, r_idx, r_cnt, r_lcnt, r_op;
  logic [7:0]    r_sum;
  logic          r_done, r_clr;
  logic [15:0]   r_mem [0:14];
  logic          w_idle, w_start, w_wr, w_bit_end, w_byte_end;
  logic [15:0]   w_word;
  logic [7:0]    w_byte;
  assign w_idle     = r_state == S_IDLE;
  assign w_start    = w_idle && (i_send || i_resend);
  assign w_wr       = i_wr_word && w_idle && !i_send && !i_resend && (r_clr || r_cnt != 4'd15);
  assign w_bit_end  = r_baud == BAUD_MAX;
  assign w_byte_end = w_bit_end && r_bit == 4'd9;
  assign w_word     = r_mem[r_idx];
  assign w_byte     = r_state == S_SYNC ? SYNC_BYTE :
                      r_state == S_HDR  ? {r_op, r_lcnt} :
                      r_state == S_DHI  ? w_word[15:8] :
                      r_state == S_DLO  ? w_word[7:0] :
                      r_state == S_CSUM ? r_sum : 8'hFF;
  // packet state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  // packet sequencing advances one field per completed byte
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_SYNC : S_IDLE;
      S_SYNC:  w_next = w_byte_end ? S_HDR : S_SYNC;
      S_HDR:   w_next = w_byte_end ? (r_lcnt == 4'd0 ? S_CSUM : S_DHI) : S_HDR;
      S_DHI:   w_next = w_byte_end ? S_DLO : S_DHI;
      S_DLO:   w_next = w_byte_end ? (r_idx == r_lcnt - 4'd1 ? S_CSUM : S_DHI) : S_DLO;
      S_CSUM:  w_next = w_byte_end ? S_IDLE : S_CSUM;
      default: w_next = S_IDLE;
    endcase
  end
  // line level derived from the current field byte and bit position
  always_comb begin
    o_busy      = !w_idle;
    o_tx_serial = w_idle ? 1'b1 : r_bit == 4'd0 ? 1'b0 : r_bit == 4'd9 ? 1'b1 : w_byte[3'(r_bit - 4'd1)];
  end
  // baud and bit counters; bytes run back to back so the bit counter simply wraps 9 -> 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_baud <= '0;
      r_bit  <= 4'd0;
    end else if (w_start || w_idle) begin
      r_baud <= '0;
      r_bit  <= 4'd0;
    end else if (w_bit_end) begin
      r_baud <= '0;
      r_bit  <= r_bit == 4'd9 ? 4'd0 : r_bit + 4'd1;
    end else r_baud <= r_baud + 1'b1;
  // latched packet parameters, word index, running checksum and done pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op   <= 4'd0;
      r_lcnt <= 4'd0;
      r_idx  <= 4'd0;
      r_sum  <= 8'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == S_CSUM && w_byte_end;
      if (w_idle && i_send) begin
        r_op   <= i_opcode;
        r_lcnt <= r_cnt;
      end
      if (w_start) begin
        r_idx <= 4'd0;
        r_sum <= 8'd0;
      end else if (w_byte_end) begin
        if (r_state == S_HDR || r_state == S_DHI || r_state == S_DLO) r_sum <= r_sum + w_byte;
        if (r_state == S_DLO) r_idx <= r_idx + 4'd1;
      end
    end
  // word count; a finished packet arms a lazy clear taken by the next write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_clr <= 1'b0;
    end else if (w_wr) begin
      r_cnt <= r_clr ? 4'd1 : r_cnt + 4'd1;
      r_clr <= 1'b0;
    end else if (r_state == S_CSUM && w_byte_end) r_clr <= 1'b1;
  // payload storage, write slot follows the count
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_clr ? 4'd0 : r_cnt] <= i_word;
  assign o_done     = r_done;
  assign o_word_cnt = r_cnt;
  assign o_full     = r_cnt == 4'd15;
endmodule

// File: tb/tb_cmd_packet_tx.sv
// tb_cmd_packet_tx: scoreboard bench with a mid-bit UART monitor and a packet-level reference model
module tb_cmd_packet_tx;
  localparam int CPB = 4;
  logic clk = 0, rst_n = 0, i_wr_word = 0, i_send = 0, i_resend = 0;
  logic [15:0] i_word = 0;
  logic [3:0]  i_opcode = 0;
  logic o_tx_serial, o_busy, o_done, o_full;
  logic [3:0] o_word_cnt;
  int n_cmp = 0, n_err = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] m_buf[15];
  int          m_cnt = 0, m_lcnt = 0;
  bit          m_clr = 0;
  logic [3:0]  m_op = 0;

  cmd_packet_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .i_wr_word(i_wr_word), .i_word(i_word), .i_opcode(i_opcode),
    .i_send(i_send), .i_resend(i_resend), .o_tx_serial(o_tx_serial), .o_busy(o_busy),
    .o_done(o_done), .o_word_cnt(o_word_cnt), .o_full(o_full));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // expected frame from the packet rules: sync, header, payload MSB first, sum of all but sync
  task automatic push_frame();
    logic [7:0] s, h;
    h = {m_op, 4'(m_lcnt)};
    s = h;
    exp_q.push_back(8'hA5);
    exp_q.push_back(h);
    for (int i = 0; i < m_lcnt; i++) begin
      exp_q.push_back(m_buf[i][15:8]);
      exp_q.push_back(m_buf[i][7:0]);
      s = s + m_buf[i][15:8] + m_buf[i][7:0];
    end
    exp_q.push_back(s);
  endtask

  // UART monitor: detect start, sample each bit in its middle, score against the queue
  initial begin
    logic [7:0] b;
    logic stp;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n && o_tx_serial == 1'b0) begin
        ab = 0;
        @(negedge clk);
        if (o_tx_serial !== 1'b0 || !rst_n) ab = 1;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = o_tx_serial;
          if (!rst_n) ab = 1;
        end
        repeat (CPB) @(negedge clk);
        stp = o_tx_serial;
        if (!rst_n) ab = 1;
        if (!ab) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h expected none", b);
          end else chk("uart_byte", {stp, b}, {1'b1, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wr(input logic [15:0] w);
    @(negedge clk);
    i_wr_word = 1;
    i_word = w;
    if (m_clr) begin
      m_buf[0] = w;
      m_cnt = 1;
      m_clr = 0;
    end else if (m_cnt < 15) begin
      m_buf[m_cnt] = w;
      m_cnt++;
    end
    @(negedge clk);
    i_wr_word = 0;
    chk("word_cnt_wr", o_word_cnt, m_cnt);
    chk("full_wr", o_full, m_cnt == 15);
  endtask

  task automatic do_pkt(input bit rs, input logic [3:0] op, input bit poke, input bit with_wr);
    int n;
    bit to;
    if (!rs) begin
      m_op = op;
      m_lcnt = m_cnt;
    end
    push_frame();
    @(negedge clk);
    i_send = !rs;
    i_resend = rs;
    i_opcode = op;
    i_wr_word = with_wr;
    i_word = 16'hBEEF;
    n = 0;
    to = 0;
    forever begin
      @(negedge clk);
      i_send = 0;
      i_resend = 0;
      i_wr_word = 0;
      if (!o_busy) break;
      n++;
      if (poke && n == 50) begin
        i_send = 1;
        i_resend = 1;
        i_wr_word = 1;
        i_opcode = ~op;
        i_word = 16'($urandom);
      end
      if (n > 3000) begin
        to = 1;
        break;
      end
    end
    chk("busy_timeout", to, 0);
    chk("busy_cycles", n, (3 + 2 * m_lcnt) * 10 * CPB);
    chk("done_pulse", o_done, 1);
    @(negedge clk);
    chk("done_clear", o_done, 0);
    chk("frame_drained", exp_q.size(), 0);
    m_clr = 1;
    chk("word_cnt_pkt", o_word_cnt, m_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit bad;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_tx", o_tx_serial, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_cnt", o_word_cnt, 0);
    chk("rst_full", o_full, 0);
    do_pkt(1, 4'd0, 0, 0);
    do_pkt(0, 4'd5, 0, 0);
    wr(16'h1234);
    wr(16'hABCD);
    do_pkt(0, 4'd3, 0, 0);
    do_pkt(1, 4'd0, 1, 0);
    wr(16'h00FF);
    do_pkt(0, 4'd2, 0, 0);
    for (int i = 0; i < 16; i++) wr(16'(i));
    do_pkt(0, 4'd1, 0, 0);
    do_pkt(0, 4'd7, 0, 1);
    for (int r = 0; r < 4; r++) begin
      int nw;
      nw = $urandom_range(0, 6);
      for (int j = 0; j < nw; j++) wr(16'($urandom));
      do_pkt(1'($urandom_range(0, 1)), 4'($urandom), 0, 0);
    end
    wr(16'h1111);
    wr(16'h2222);
    m_op = 4'h9;
    m_lcnt = m_cnt;
    push_frame();
    @(negedge clk);
    i_send = 1;
    i_opcode = 4'h9;
    @(negedge clk);
    i_send = 0;
    repeat (129) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_tx", o_tx_serial, 1);
    chk("abort_busy", o_busy, 0);
    repeat (40) @(negedge clk);
    exp_q.delete();
    rst_n = 1;
    m_cnt = 0;
    m_clr = 0;
    m_op = 0;
    m_lcnt = 0;
    @(negedge clk);
    chk("post_rst_cnt", o_word_cnt, 0);
    chk("post_rst_full", o_full, 0);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (o_tx_serial !== 1'b1 || o_busy !== 1'b0) bad = 1;
    end
    chk("idle_after_rst", bad, 0);
    do_pkt(1, 4'd0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
